smart_cargo_tx_conteudo: RTL and testbench
==========================================

# smart_cargo_tx_conteudo

Reports the elevator's cargo contents to the host over UART 8N1. On a start pulse it transmits a fixed-format ASCII frame:
- a header byte carrying the current floor;
- one byte per slot of the elevator-content RAM;
- a line-feed terminator.

It sits downstream of the cargo datapath's elevator-content RAM. It drives that RAM's read address and consumes its tipo/destino read data, which the datapath otherwise leaves unused.

## Interface
Parameters:
- SLOTS, 4: number of content-RAM slots scanned, addresses 0..SLOTS-1.
- ADDR_W, 2: width of rd_addr; must satisfy SLOTS ≤ 2^ADDR_W.
- CLKS_PER_BIT, 5208: clock cycles per UART bit (50 MHz / 9600 baud); must be ≥ 2.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- iniciar  in  1  start request; sampled only in IDLE.
- andar_atual  in  2  current floor; sampled on the accepting edge.
- tipo_objeto  in  2  content-RAM read data, object type (00 = empty slot).
- destino_objeto  in  2  content-RAM read data, destination floor.
- rd_addr  out  ADDR_W  content-RAM read address.
- TX  out  1  serial line; idles high.
- ocupado  out  1  high from the accepting edge until the pronto edge.
- pronto  out  1  one-cycle pulse at frame completion.
- db_estado  out  4  FSM state code, debug only.

## Operation
Frame format:
- Header: 0x40 | {6'b0, andar_atual}.
- One byte per slot: 0x30 | {4'b0, tipo_objeto, destino_objeto}, giving ASCII '0'..'?'.
- Terminator: 0x0A.

UART format:
- 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Each bit lasts exactly CLKS_PER_BIT cycles.
- TX is registered and glitch-free.

FSM states and transitions:
- IDLE -> CABECALHO when iniciar=1.
- CABECALHO transmits the header byte, then -> LEITURA.
- LEITURA drives rd_addr = slot.
- CAPTURA latches tipo/destino (RAM read is synchronous, 1-cycle latency), then -> SLOT.
- SLOT transmits the slot byte.
  - If slot < SLOTS-1: slot increments and -> LEITURA.
  - If slot = SLOTS-1: -> PAUSA.
- PAUSA is one idle cycle, then -> TERMINADOR.
- TERMINADOR transmits 0x0A, then -> FIM.
- FIM pulses pronto and returns to IDLE.

Counters:
- Bit counter 0..9.
- Baud counter 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary.
- Slot counter ADDR_W bits, starts at 0, never wraps mid-frame.

Behaviour rules:
- rd_addr is 0 in IDLE and holds the current slot index during LEITURA/CAPTURA/SLOT.
- andar_atual and RAM data are captured once per byte. Later input changes do not alter a byte already in flight.
- iniciar while ocupado=1 is ignored; it is not queued.
- reset mid-frame: on the next edge TX=1, state=IDLE, and all counters, rd_addr, ocupado and pronto are 0. The partial byte is abandoned.
- reset and iniciar high on the same edge: reset wins.

## Timing
Reset values: TX=1, ocupado=0, pronto=0, rd_addr=0, db_estado=0 (IDLE).

Start: iniciar sampled high at edge E0. TX falls to 0 and ocupado rises at edge E0+1.

Between bytes:
- Exactly 2 idle-high cycles separate the end of one stop bit from the next start bit.
- This gap comes from LEITURA+CAPTURA for slot bytes and from PAUSA+one setup cycle for the terminator.

Completion:
- With N transmitted bytes, the last stop bit ends at edge E0+1+10·CLKS_PER_BIT·N+2·(N−1).
- pronto is high for the single cycle following that edge.
- ocupado falls on that same edge.
- A new iniciar is accepted on the cycle after pronto.

## Configuration
Macro SMART_CARGO_TX_SKIP_EMPTY_EN:
- Defined: slots with tipo_objeto=00 are not transmitted. A skipped slot still costs its 2 fetch cycles and then moves directly to the next slot's LEITURA, or to PAUSA if it is the last slot.
- Undefined: every slot is transmitted regardless of type. N = SLOTS+2.

## Test plan
- Reset: assert reset 3 cycles -> TX=1, ocupado=0, pronto=0, rd_addr=0, db_estado=0; TX stays 1 for 100 cycles with iniciar=0.
- Full frame, macro off, CLKS_PER_BIT=4: andar=2, slots {tipo,destino}={01,11},{00,00},{10,00},{11,01}, iniciar at E0 -> bytes 0x42,0x37,0x30,0x38,0x3D,0x0A; each bit exactly 4 cycles; pronto single pulse at E0+251.
- Same stimulus with SMART_CARGO_TX_SKIP_EMPTY_EN -> bytes 0x42,0x37,0x38,0x3D,0x0A; pronto at E0+211.
- Busy guard: pulse iniciar again at E0+50 and E0+200 -> no frame restart, identical byte stream, exactly one pronto pulse.
- Mid-frame reset: reset at E0+60 for 1 cycle -> TX=1 and ocupado=0 on next edge; iniciar 5 cycles later produces a complete, correct frame.
- Data stability: change andar_atual and RAM contents while slot 1 is transmitting -> header and slot-1 bytes unchanged; slot 2 reflects new RAM data.

Source files
------------

// File: rtl/smart_cargo_tx_conteudo.sv
// UART 8N1 reporter of floor and elevator-content RAM slots, framed as header, one byte per slot, LF.
// Optional SMART_CARGO_TX_SKIP_EMPTY_EN: empty slots (tipo_objeto = 00) are fetched but not sent.
module smart_cargo_tx_conteudo #(
    parameter int SLOTS        = 4,
    parameter int ADDR_W       = 2,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [1:0]        andar_atual,
    input  logic [1:0]        tipo_objeto,
    input  logic [1:0]        destino_objeto,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              TX,
    output logic              ocupado,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        CABECALHO  = 4'd1,
        LEITURA    = 4'd2,
        CAPTURA    = 4'd3,
        SLOT       = 4'd4,
        PAUSA      = 4'd5,
        TERMINADOR = 4'd6,
        FIM        = 4'd7
    } estado_t;

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] SLOT_LAST = ADDR_W'(SLOTS - 1);

    estado_t           state_q, state_d;
    logic [ADDR_W-1:0] slot_q, slot_d;
    logic [7:0]        shift_q, shift_d;
    logic [3:0]        bit_q, bit_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic              ativo_q, ativo_d;
    logic              tx_q, tx_d;
    logic              ocupado_q, ocupado_d;
    logic              pronto_q, pronto_d;

    logic              bit_fim;
    logic              lancar;
    logic              ultimo;
    logic              skip_slot;

`ifdef SMART_CARGO_TX_SKIP_EMPTY_EN
    assign skip_slot = (tipo_objeto == 2'b00);
`else
    assign skip_slot = 1'b0;
`endif

    assign bit_fim = ativo_q && (baud_q == BAUD_LAST) && (bit_q == 4'd9);
    assign ultimo  = (slot_q == SLOT_LAST);

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        baud_d    = baud_q;
        ativo_d   = ativo_q;
        tx_d      = tx_q;
        ocupado_d = ocupado_q;
        pronto_d  = 1'b0;
        lancar    = 1'b0;

        // Bit engine: start bit, 8 data bits LSB first from shift_q, stop bit.
        if (ativo_q) begin
            if (baud_q == BAUD_LAST) begin
                baud_d = '0;
                if (bit_q == 4'd9) begin
                    ativo_d = 1'b0;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end else begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd8) begin
                        tx_d = 1'b1;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end else begin
                baud_d = baud_q + BAUD_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (iniciar) begin
                    state_d = CABECALHO;
                    shift_d = {6'b010000, andar_atual};
                end
            end
            CABECALHO: begin
                if (!ativo_q) begin
                    lancar    = 1'b1;
                    ocupado_d = 1'b1;
                end else if (bit_fim) begin
                    state_d = LEITURA;
                end
            end
            LEITURA: state_d = CAPTURA;
            CAPTURA: begin
                // Slot bytes launch straight from the capture edge so the fetch pair is the whole gap.
                if (skip_slot) begin
                    state_d = ultimo ? PAUSA : LEITURA;
                    slot_d  = ultimo ? slot_q : slot_q + ADDR_W'(1);
                end else begin
                    state_d = SLOT;
                    shift_d = {4'h3, tipo_objeto, destino_objeto};
                    lancar  = 1'b1;
                end
            end
            SLOT: begin
                if (bit_fim) begin
                    state_d = ultimo ? PAUSA : LEITURA;
                    slot_d  = ultimo ? slot_q : slot_q + ADDR_W'(1);
                end
            end
            PAUSA: begin
                state_d = TERMINADOR;
                shift_d = 8'h0A;
            end
            TERMINADOR: begin
                if (!ativo_q) begin
                    lancar = 1'b1;
                end else if (bit_fim) begin
                    state_d   = FIM;
                    ocupado_d = 1'b0;
                    pronto_d  = 1'b1;
                end
            end
            FIM: begin
                state_d = IDLE;
                slot_d  = '0;
            end
            default: state_d = IDLE;
        endcase

        if (lancar) begin
            tx_d    = 1'b0;
            ativo_d = 1'b1;
            bit_d   = '0;
            baud_d  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            shift_q   <= '0;
            bit_q     <= '0;
            baud_q    <= '0;
            ativo_q   <= 1'b0;
            tx_q      <= 1'b1;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            baud_q    <= baud_d;
            ativo_q   <= ativo_d;
            tx_q      <= tx_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
        end
    end

    assign rd_addr   = slot_q;
    assign TX        = tx_q;
    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;
    assign db_estado = state_q;

endmodule

// File: tb/tb_smart_cargo_tx_conteudo.sv
// Directed bench for smart_cargo_tx_conteudo at CLKS_PER_BIT=4; expectations follow SMART_CARGO_TX_SKIP_EMPTY_EN.
module tb_smart_cargo_tx_conteudo;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [1:0] andar_atual;
    logic [1:0] tipo_objeto;
    logic [1:0] destino_objeto;
    logic [1:0] rd_addr;
    logic       TX;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    smart_cargo_tx_conteudo #(
        .SLOTS(4),
        .ADDR_W(2),
        .CLKS_PER_BIT(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .iniciar(iniciar),
        .andar_atual(andar_atual),
        .tipo_objeto(tipo_objeto),
        .destino_objeto(destino_objeto),
        .rd_addr(rd_addr),
        .TX(TX),
        .ocupado(ocupado),
        .pronto(pronto),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Content RAM with synchronous read, {tipo, destino} per slot.
    logic [3:0] mem [4];
    logic [3:0] ram_q = 4'h0;
    always @(posedge clock) ram_q <= mem[rd_addr];
    assign tipo_objeto    = ram_q[3:2];
    assign destino_objeto = ram_q[1:0];

    // UART receiver sampling every cycle on the falling edge; checks each bit is flat for 4 cycles.
    logic       rx_on = 1'b0;
    int         rx_cnt = 0;
    logic [9:0] rx_bits = '0;
    int         rx_start = 0;
    logic [7:0] rx_bytes[$];
    int         rx_starts[$];
    int         glitches = 0;
    int         framing = 0;

    always @(negedge clock) begin
        if (reset === 1'b1) begin
            rx_on <= 1'b0;
        end else if (!rx_on) begin
            if (TX === 1'b0) begin
                rx_on    <= 1'b1;
                rx_cnt   <= 1;
                rx_bits  <= '0;
                rx_start <= cyc;
            end
        end else begin
            if (rx_cnt % 4 == 0) rx_bits[rx_cnt / 4] <= TX;
            else if (TX !== rx_bits[rx_cnt / 4]) glitches <= glitches + 1;
            if (rx_cnt == 39) begin
                rx_bytes.push_back(rx_bits[8:1]);
                rx_starts.push_back(rx_start);
                if (rx_bits[9] !== 1'b1) framing <= framing + 1;
                rx_on <= 1'b0;
            end else begin
                rx_cnt <= rx_cnt + 1;
            end
        end
    end

    int pronto_cnt = 0;
    int pronto_cyc = 0;
    always @(negedge clock) begin
        if (pronto === 1'b1) begin
            pronto_cnt <= pronto_cnt + 1;
            pronto_cyc <= cyc;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic at_neg(input int n);
        go(n);
        if (clock) @(negedge clock);
    endtask

    task automatic check_frame(input string nm, input int e0, input int base,
                               input logic [7:0] eb [6], input int es [6], input int n);
        int sz;
        sz = rx_bytes.size();
        check({nm, " nbytes"}, 32'(sz - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s byte%0d", nm, i),
                  (base + i < sz) ? 32'(rx_bytes[base + i]) : 32'hxxxxxxxx, 32'(eb[i]));
            check($sformatf("%s start%0d", nm, i),
                  (base + i < sz) ? 32'(rx_starts[base + i] - e0) : 32'hffffffff, 32'(es[i]));
        end
    endtask

    logic [7:0] eb_a [6];
    logic [7:0] eb_b [6];
    int         es_a [6];
    int         nb;
    int         pdone;
    logic [1:0] rd100;

    int e0, base, pc0, idle_bad;

    initial begin
`ifdef SMART_CARGO_TX_SKIP_EMPTY_EN
        eb_a  = '{8'h42, 8'h37, 8'h38, 8'h3D, 8'h0A, 8'h00};
        eb_b  = '{8'h42, 8'h37, 8'h38, 8'h3D, 8'h0A, 8'h00};
        es_a  = '{1, 43, 87, 129, 171, 0};
        nb    = 5;
        pdone = 211;
        rd100 = 2'd2;
`else
        eb_a  = '{8'h42, 8'h37, 8'h30, 8'h38, 8'h3D, 8'h0A};
        eb_b  = '{8'h42, 8'h37, 8'h30, 8'h3E, 8'h3D, 8'h0A};
        es_a  = '{1, 43, 85, 127, 169, 211};
        nb    = 6;
        pdone = 251;
        rd100 = 2'd1;
`endif
        mem[0] = 4'b0111;
        mem[1] = 4'b0000;
        mem[2] = 4'b1000;
        mem[3] = 4'b1101;
        andar_atual = 2'd2;
        reset   = 1'b1;
        iniciar = 1'b1;  // reset must win over iniciar

        at_neg(3);
        check("rst TX", 32'(TX), 32'd1);
        check("rst ocupado", 32'(ocupado), 32'd0);
        check("rst pronto", 32'(pronto), 32'd0);
        check("rst rd_addr", 32'(rd_addr), 32'd0);
        check("rst estado", 32'(db_estado), 32'd0);
        reset   = 1'b0;
        iniciar = 1'b0;

        idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            at_neg(cyc + 1);
            if (TX !== 1'b1) idle_bad++;
        end
        check("idle TX high", 32'(idle_bad), 32'd0);
        check("idle no bytes", 32'(rx_bytes.size()), 32'd0);

        // Frame 1: full frame with timing probes.
        base = rx_bytes.size();
        pc0  = pronto_cnt;
        iniciar = 1'b1;
        e0 = cyc + 1;
        go(e0);
        iniciar = 1'b0;
        at_neg(e0);
        check("f1 E0 TX", 32'(TX), 32'd1);
        check("f1 E0 ocupado", 32'(ocupado), 32'd0);
        check("f1 E0 estado", 32'(db_estado), 32'd1);
        at_neg(e0 + 1);
        check("f1 E0+1 TX", 32'(TX), 32'd0);
        check("f1 E0+1 ocupado", 32'(ocupado), 32'd1);
        at_neg(e0 + 50);
        check("f1 +50 estado", 32'(db_estado), 32'd4);
        check("f1 +50 rd_addr", 32'(rd_addr), 32'd0);
        at_neg(e0 + 100);
        check("f1 +100 rd_addr", 32'(rd_addr), 32'(rd100));
        at_neg(e0 + pdone - 1);
        check("f1 pre pronto", 32'(pronto), 32'd0);
        check("f1 pre ocupado", 32'(ocupado), 32'd1);
        at_neg(e0 + pdone);
        check("f1 pronto", 32'(pronto), 32'd1);
        check("f1 ocupado fall", 32'(ocupado), 32'd0);
        at_neg(e0 + pdone + 1);
        check("f1 pronto pulse", 32'(pronto), 32'd0);
        check("f1 back idle", 32'(db_estado), 32'd0);
        check("f1 idle rd_addr", 32'(rd_addr), 32'd0);
        check_frame("f1", e0, base, eb_a, es_a, nb);
        check("f1 pronto count", 32'(pronto_cnt - pc0), 32'd1);

        // Frame 2: accepted on the first legal cycle, with ignored iniciar pulses while busy.
        base = rx_bytes.size();
        pc0  = pronto_cnt;
        iniciar = 1'b1;
        e0 = cyc + 1;
        go(e0);
        iniciar = 1'b0;
        go(e0 + 49);
        iniciar = 1'b1;
        go(e0 + 50);
        iniciar = 1'b0;
        go(e0 + 199);
        iniciar = 1'b1;
        go(e0 + 200);
        iniciar = 1'b0;
        at_neg(e0 + pdone + 30);
        check_frame("f2", e0, base, eb_a, es_a, nb);
        check("f2 pronto count", 32'(pronto_cnt - pc0), 32'd1);
        check("f2 pronto cycle", 32'(pronto_cyc - e0), 32'(pdone));

        // Frame 3: reset mid-frame, then a clean restart.
        pc0 = pronto_cnt;
        iniciar = 1'b1;
        e0 = cyc + 1;
        go(e0);
        iniciar = 1'b0;
        go(e0 + 59);
        reset = 1'b1;
        go(e0 + 60);
        reset = 1'b0;
        at_neg(e0 + 60);
        check("f3 rst TX", 32'(TX), 32'd1);
        check("f3 rst ocupado", 32'(ocupado), 32'd0);
        check("f3 rst estado", 32'(db_estado), 32'd0);
        check("f3 rst rd_addr", 32'(rd_addr), 32'd0);
        go(e0 + 64);
        base = rx_bytes.size();
        iniciar = 1'b1;
        e0 = e0 + 65;
        go(e0);
        iniciar = 1'b0;
        at_neg(e0 + pdone + 1);
        check_frame("f3", e0, base, eb_a, es_a, nb);
        check("f3 pronto count", 32'(pronto_cnt - pc0), 32'd1);

        // Frame 4: inputs change while slot 1 is on the line.
        base = rx_bytes.size();
        iniciar = 1'b1;
        e0 = cyc + 1;
        go(e0);
        iniciar = 1'b0;
        go(e0 + 100);
        andar_atual = 2'd1;
        mem[1] = 4'b0101;
        mem[2] = 4'b1110;
        at_neg(e0 + pdone + 1);
        check_frame("f4", e0, base, eb_b, es_a, nb);

        check("bit glitches", 32'(glitches), 32'd0);
        check("framing errors", 32'(framing), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
